// File: rtl/step_pkg.sv
// Shared types and helpers for the step sequencer transport.
// State encoding, step index width and loop-length resolution.
package step_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  localparam int STEP_W = 4;

  // A zero or oversized loop length falls back to the full pattern.
  function automatic logic [STEP_W:0] eff_len(input logic [STEP_W-1:0] length,
                                               input int num_steps);
    logic [STEP_W:0] cap_s;
    cap_s = (STEP_W+1)'(num_steps);
    if ((length == {STEP_W{1'b0}}) || ({1'b0, length} > cap_s)) begin
      return cap_s;
    end else begin
      return {1'b0, length};
    end
  endfunction

endpackage

// File: rtl/step_tick_divider.sv
// Reloadable tempo down-counter; zero flags the clock on which a step is due.
// Priority: clear, load, freeze, then decrement (holding at zero).
module step_tick_divider #(
  parameter int W = 24
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  input  logic         load,
  input  logic         freeze,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Counter register
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      cnt_r <= {W{1'b0}};
    end else if (clear) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (freeze) begin
      cnt_r <= cnt_r;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/step_transport.sv
// Step sequencer transport: play/pause/stop FSM, tempo-driven step counter,
// trigger pattern storage and per-track gate pulses. All outputs registered.
module step_transport
  import step_pkg::*;
#(
  parameter int NUM_STEPS   = 8,
  parameter int NUM_TRACKS  = 4,
  parameter int DIV_WIDTH   = 24,
  parameter int GATE_CYCLES = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  PLAY,
  input  logic                  PAUSE,
  input  logic                  STOP,
  input  logic [DIV_WIDTH-1:0]  TICK_DIV,
  input  logic [STEP_W-1:0]     LENGTH,
  input  logic                  PAT_WE,
  input  logic [STEP_W-1:0]     PAT_STEP,
  input  logic [NUM_TRACKS-1:0] PAT_DATA,
  output logic [STEP_W-1:0]     STEP_NUM,
  output logic [NUM_STEPS-1:0]  ACTIVE_STEP,
  output logic                  STEP_STROBE,
  output logic [NUM_TRACKS-1:0] GATE,
  output logic                  RUNNING
);

  localparam int GCW = $clog2(GATE_CYCLES + 1);

  state_t                state_r, state_nxt_s;
  logic [STEP_W-1:0]     step_r, step_nxt_s;
  logic                  strobe_r, strobe_nxt_s;
  logic [NUM_STEPS-1:0]  active_r, active_nxt_s;
  logic [NUM_TRACKS-1:0] gate_r, gate_nxt_s, pat_rd_s;
  logic [GCW-1:0]        gate_cnt_r, gate_cnt_nxt_s;
  logic                  running_r;
  logic [NUM_TRACKS-1:0] pattern_r [NUM_STEPS];
  logic                  run_tick_s, div_load_s, div_freeze_s, div_clear_s, div_zero_s;
  logic [STEP_W:0]       eff_len_s;

  assign eff_len_s = eff_len(LENGTH, NUM_STEPS);

  step_tick_divider #(.W(DIV_WIDTH)) u_div (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .load     (div_load_s),
    .freeze   (div_freeze_s),
    .clear    (div_clear_s),
    .load_val (TICK_DIV),
    .zero     (div_zero_s)
  );

  // Transport FSM and step advance; a resume edge counts as a running clock.
  always_comb begin
    state_nxt_s  = state_r;
    step_nxt_s   = step_r;
    strobe_nxt_s = 1'b0;
    run_tick_s   = 1'b0;
    div_load_s   = 1'b0;
    div_freeze_s = 1'b0;
    div_clear_s  = 1'b0;
    case (state_r)
      ST_STOPPED: begin
        if (PLAY && !STOP) begin
          state_nxt_s  = ST_RUNNING;
          step_nxt_s   = {STEP_W{1'b0}};
          strobe_nxt_s = 1'b1;
          div_load_s   = 1'b1;
        end else begin
          step_nxt_s  = {STEP_W{1'b0}};
          div_clear_s = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (STOP) begin
          state_nxt_s = ST_STOPPED;
          step_nxt_s  = {STEP_W{1'b0}};
          div_clear_s = 1'b1;
        end else if (PAUSE) begin
          state_nxt_s  = ST_PAUSED;
          div_freeze_s = 1'b1;
        end else begin
          run_tick_s = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (STOP) begin
          state_nxt_s = ST_STOPPED;
          step_nxt_s  = {STEP_W{1'b0}};
          div_clear_s = 1'b1;
        end else if (PLAY) begin
          state_nxt_s = ST_RUNNING;
          run_tick_s  = 1'b1;
        end else begin
          div_freeze_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_STOPPED;
        step_nxt_s  = {STEP_W{1'b0}};
        div_clear_s = 1'b1;
      end
    endcase

    if (run_tick_s && div_zero_s) begin
      strobe_nxt_s = 1'b1;
      div_load_s   = 1'b1;
      if ({1'b0, step_r} >= (eff_len_s - (STEP_W+1)'(1))) begin
        step_nxt_s = {STEP_W{1'b0}};
      end else begin
        step_nxt_s = step_r + STEP_W'(1);
      end
    end else begin
      div_load_s = div_load_s;
    end
  end

  // Pattern lookup for the step being entered and its one-hot display
  always_comb begin
    pat_rd_s     = {NUM_TRACKS{1'b0}};
    active_nxt_s = {NUM_STEPS{1'b0}};
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (step_nxt_s == STEP_W'(i)) begin
        pat_rd_s        = pattern_r[i];
        active_nxt_s[i] = (state_nxt_s != ST_STOPPED);
      end else begin
        active_nxt_s[i] = 1'b0;
      end
    end
  end

  // Gate timer: a strobe reloads, otherwise count down; dark unless running.
  always_comb begin
    gate_nxt_s     = {NUM_TRACKS{1'b0}};
    gate_cnt_nxt_s = {GCW{1'b0}};
    if (state_nxt_s != ST_RUNNING) begin
      gate_nxt_s     = {NUM_TRACKS{1'b0}};
      gate_cnt_nxt_s = {GCW{1'b0}};
    end else if (strobe_nxt_s) begin
      gate_nxt_s     = pat_rd_s;
      gate_cnt_nxt_s = GCW'(GATE_CYCLES);
    end else if (gate_cnt_r > GCW'(1)) begin
      gate_nxt_s     = gate_r;
      gate_cnt_nxt_s = gate_cnt_r - GCW'(1);
    end else begin
      gate_nxt_s     = {NUM_TRACKS{1'b0}};
      gate_cnt_nxt_s = {GCW{1'b0}};
    end
  end

  // Transport and output registers
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_r    <= ST_STOPPED;
      step_r     <= {STEP_W{1'b0}};
      strobe_r   <= 1'b0;
      active_r   <= {NUM_STEPS{1'b0}};
      gate_r     <= {NUM_TRACKS{1'b0}};
      gate_cnt_r <= {GCW{1'b0}};
      running_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      step_r     <= step_nxt_s;
      strobe_r   <= strobe_nxt_s;
      active_r   <= active_nxt_s;
      gate_r     <= gate_nxt_s;
      gate_cnt_r <= gate_cnt_nxt_s;
      running_r  <= (state_nxt_s == ST_RUNNING);
    end
  end

  // Pattern storage; out-of-range write addresses are dropped
  always_ff @(posedge CLOCK) begin
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (!RESET_N) begin
        pattern_r[i] <= {NUM_TRACKS{1'b0}};
      end else if (PAT_WE && (PAT_STEP == STEP_W'(i))) begin
        pattern_r[i] <= PAT_DATA;
      end else begin
        pattern_r[i] <= pattern_r[i];
      end
    end
  end

  assign STEP_NUM    = step_r;
  assign ACTIVE_STEP = active_r;
  assign STEP_STROBE = strobe_r;
  assign GATE        = gate_r;
  assign RUNNING     = running_r;

endmodule

// File: tb/tb_step_transport.sv
// Directed testbench for step_transport with hand-computed expectations.
module tb_step_transport;

  logic        CLOCK;
  logic        RESET_N;
  logic        PLAY, PAUSE, STOP;
  logic [23:0] TICK_DIV;
  logic [3:0]  LENGTH;
  logic        PAT_WE;
  logic [3:0]  PAT_STEP;
  logic [3:0]  PAT_DATA;
  logic [3:0]  STEP_NUM;
  logic [7:0]  ACTIVE_STEP;
  logic        STEP_STROBE;
  logic [3:0]  GATE;
  logic        RUNNING;

  int check_cnt = 0;
  int error_cnt = 0;

  step_transport #(
    .NUM_STEPS(8), .NUM_TRACKS(4), .DIV_WIDTH(24), .GATE_CYCLES(4)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .PLAY(PLAY), .PAUSE(PAUSE), .STOP(STOP),
    .TICK_DIV(TICK_DIV), .LENGTH(LENGTH), .PAT_WE(PAT_WE), .PAT_STEP(PAT_STEP),
    .PAT_DATA(PAT_DATA), .STEP_NUM(STEP_NUM), .ACTIVE_STEP(ACTIVE_STEP),
    .STEP_STROBE(STEP_STROBE), .GATE(GATE), .RUNNING(RUNNING)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pat_write(input logic [3:0] stp, input logic [3:0] dat);
    PAT_WE = 1'b1; PAT_STEP = stp; PAT_DATA = dat;
    tick();
    PAT_WE = 1'b0;
  endtask

  task automatic pulse_play();
    PLAY = 1'b1; tick(); PLAY = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_value({tag, "_step"}, 32'(STEP_NUM), 32'h0);
    check_value({tag, "_active"}, 32'(ACTIVE_STEP), 32'h0);
    check_value({tag, "_strobe"}, 32'(STEP_STROBE), 32'h0);
    check_value({tag, "_gate"}, 32'(GATE), 32'h0);
    check_value({tag, "_running"}, 32'(RUNNING), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0; PLAY = 1'b0; PAUSE = 1'b0; STOP = 1'b0;
    TICK_DIV = 24'd3; LENGTH = 4'd0; PAT_WE = 1'b0; PAT_STEP = 4'd0; PAT_DATA = 4'd0;
    run(3);
    RESET_N = 1'b1;
    tick();
    check_idle("reset");

    // PAUSE while stopped is ignored
    PAUSE = 1'b1; tick(); PAUSE = 1'b0;
    check_value("pause_in_stop_running", 32'(RUNNING), 32'h0);

    // Step 2 gets 0101; address 9 is out of range and must not alias step 1
    pat_write(4'd2, 4'b0101);
    pat_write(4'd9, 4'b1111);

    // Full 8-step loop with a 4-clock period, gate equal to the period
    TICK_DIV = 24'd3; LENGTH = 4'd0;
    pulse_play();
    check_value("play_running", 32'(RUNNING), 32'h1);
    for (int s = 0; s < 9; s++) begin
      for (int c = 0; c < 4; c++) begin
        check_value($sformatf("loop_s%0d_c%0d_strobe", s, c), 32'(STEP_STROBE), (c == 0) ? 32'h1 : 32'h0);
        check_value($sformatf("loop_s%0d_c%0d_step", s, c), 32'(STEP_NUM), 32'(s % 8));
        check_value($sformatf("loop_s%0d_c%0d_active", s, c), 32'(ACTIVE_STEP), 32'(1 << (s % 8)));
        check_value($sformatf("loop_s%0d_c%0d_gate", s, c), 32'(GATE), ((s % 8) == 2) ? 32'h5 : 32'h0);
        tick();
      end
    end

    // Simultaneous PLAY/PAUSE/STOP: STOP wins
    PLAY = 1'b1; PAUSE = 1'b1; STOP = 1'b1;
    tick();
    PLAY = 1'b0; PAUSE = 1'b0; STOP = 1'b0;
    check_idle("stop_all");

    // Short loop, then shrink the length while sitting on the last step
    LENGTH = 4'd3; TICK_DIV = 24'd1;
    pulse_play();
    check_value("len3_first", 32'(STEP_NUM), 32'h0);
    run(2); check_value("len3_a", 32'(STEP_NUM), 32'h1);
    run(2); check_value("len3_b", 32'(STEP_NUM), 32'h2);
    run(2); check_value("len3_wrap", 32'(STEP_NUM), 32'h0);
    check_value("len3_wrap_strobe", 32'(STEP_STROBE), 32'h1);
    run(2); check_value("len3_c", 32'(STEP_NUM), 32'h1);
    run(2); check_value("len3_d", 32'(STEP_NUM), 32'h2);
    LENGTH = 4'd2;
    tick(); check_value("len2_no_jump", 32'(STEP_NUM), 32'h2);
    tick(); check_value("len2_wrap", 32'(STEP_NUM), 32'h0);
    run(2); check_value("len2_a", 32'(STEP_NUM), 32'h1);
    run(2); check_value("len2_b", 32'(STEP_NUM), 32'h0);
    STOP = 1'b1; tick(); STOP = 1'b0;
    check_idle("stop_len");

    // Pause two clocks after a strobe with a 6-clock period, then resume
    pat_write(4'd0, 4'b1010);
    TICK_DIV = 24'd5; LENGTH = 4'd0;
    pulse_play();
    check_value("pause_entry_gate", 32'(GATE), 32'ha);
    run(2);
    check_value("pause_pre_gate", 32'(GATE), 32'ha);
    PAUSE = 1'b1; tick(); PAUSE = 1'b0;
    check_value("paused_running", 32'(RUNNING), 32'h0);
    check_value("paused_gate", 32'(GATE), 32'h0);
    check_value("paused_active", 32'(ACTIVE_STEP), 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_value($sformatf("hold%0d_strobe", k), 32'(STEP_STROBE), 32'h0);
      check_value($sformatf("hold%0d_step", k), 32'(STEP_NUM), 32'h0);
    end
    pulse_play();
    check_value("resume_running", 32'(RUNNING), 32'h1);
    check_value("resume_no_strobe", 32'(STEP_STROBE), 32'h0);
    tick(); check_value("resume_p2_strobe", 32'(STEP_STROBE), 32'h0);
    tick(); check_value("resume_p3_strobe", 32'(STEP_STROBE), 32'h0);
    tick(); check_value("resume_p4_strobe", 32'(STEP_STROBE), 32'h1);
    check_value("resume_p4_step", 32'(STEP_NUM), 32'h1);

    // Reset while running: everything clears, including the pattern
    RESET_N = 1'b0; tick(); RESET_N = 1'b1;
    check_idle("mid_reset");
    TICK_DIV = 24'd0;
    pulse_play();
    check_value("post_reset_step0_gate", 32'(GATE), 32'h0);
    check_value("post_reset_strobe", 32'(STEP_STROBE), 32'h1);
    tick(); check_value("post_reset_fast_step", 32'(STEP_NUM), 32'h1);
    check_value("post_reset_fast_strobe", 32'(STEP_STROBE), 32'h1);
    tick(); check_value("post_reset_step2_gate", 32'(GATE), 32'h0);
    STOP = 1'b1; tick(); STOP = 1'b0;
    check_idle("stop_fast");

    // Every clock a step, all triggers set: gate stays high; LENGTH 9 means 8
    for (int i = 0; i < 8; i++) pat_write(4'(i), 4'b1111);
    LENGTH = 4'd9; TICK_DIV = 24'd0;
    pulse_play();
    for (int k = 0; k < 12; k++) begin
      check_value($sformatf("fast%0d_strobe", k), 32'(STEP_STROBE), 32'h1);
      check_value($sformatf("fast%0d_gate", k), 32'(GATE), 32'hf);
      check_value($sformatf("fast%0d_step", k), 32'(STEP_NUM), 32'(k % 8));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
